// File: rtl/ciphertext_capture_ram_if.sv
// Ciphertext valid/ready handshake between the AES core and the capture RAM.
// master: drives ct_valid_i/ct_i, slave: drives ct_ready_o.
interface ciphertext_capture_ram_if #(
  parameter int TEXT_WIDTH = 128
);
  logic                  ct_valid_i;
  logic [TEXT_WIDTH-1:0] ct_i;
  logic                  ct_ready_o;

  modport master (
    output ct_valid_i,
    output ct_i,
    input  ct_ready_o
  );

  modport slave (
    input  ct_valid_i,
    input  ct_i,
    output ct_ready_o
  );
endinterface

// File: rtl/ciphertext_capture_ram.sv
// Captures len_i ciphertext blocks into an indexed RAM after start_i.
// Ports: clk_i/rst_n_i, start_i/len_i, ct_if (slave handshake),
// wr_ptr_o/count_o/done_o/overflow_o status, rd_addr_i -> rd_data_q.
module ciphertext_capture_ram #(
  parameter int TEXT_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 4,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  ciphertext_capture_ram_if.slave ct_if,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  done_o,
  output logic                  overflow_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [TEXT_WIDTH-1:0] rd_data_q
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MEM_SZ = CW'(MEMORY_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         target_q, target_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [TEXT_WIDTH-1:0] rd_data_d;
  logic                  mem_we;
  logic [CW-1:0]         clamp_len;
  logic [CW-1:0]         count_inc;

  logic [TEXT_WIDTH-1:0] mem_q [MEMORY_SIZE];

  assign clamp_len = (len_i > MEM_SZ) ? MEM_SZ : len_i;
  assign count_inc = count_q + 1'b1;

  // start_i pre-empts any write in the same cycle
  assign mem_we = (state_q == S_CAPTURE) && ct_if.ct_valid_i && !start_i;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (start_i) begin
      target_d   = clamp_len;
      count_d    = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
      state_d    = (clamp_len == '0) ? S_DONE : S_CAPTURE;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_CAPTURE: begin
          if (ct_if.ct_valid_i) begin
            count_d  = count_inc;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_inc == target_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (ct_if.ct_valid_i) overflow_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr_i} < MEM_SZ) rd_data_d = mem_q[rd_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Contents survive reset; read above sees the pre-write value
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= ct_if.ct_i;
  end

  assign ct_if.ct_ready_o = (state_q == S_CAPTURE);
  assign done_o           = (state_q == S_DONE);
  assign count_o          = count_q;
  assign wr_ptr_o         = wr_ptr_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_ciphertext_capture_ram.sv
// Directed bench for ciphertext_capture_ram with a behavioural model.
// Model is compared every cycle; literal checks pin key expectations.
module tb_ciphertext_capture_ram;

  localparam int TW = 128;
  localparam int AW = 4;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          done;
  logic          overflow;
  logic [TW-1:0] rd_data;

  ciphertext_capture_ram_if #(.TEXT_WIDTH(TW)) ct_if ();

  ciphertext_capture_ram #(
    .TEXT_WIDTH(TW), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .len_i(len),
    .ct_if(ct_if.slave),
    .wr_ptr_o(wr_ptr),
    .count_o(count),
    .done_o(done),
    .overflow_o(overflow),
    .rd_addr_i(rd_addr),
    .rd_data_q(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(string name, logic [TW-1:0] got, logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model
  int            m_target, m_count;
  bit            m_cap, m_done, m_ovf;
  logic [TW-1:0] m_mem [MS];
  bit            m_known [MS];
  logic [TW-1:0] m_rd;
  bit            m_rd_known;

  task automatic model_reset();
    m_target = 0; m_count = 0;
    m_cap = 0; m_done = 0; m_ovf = 0;
    m_rd = '0; m_rd_known = 1;
  endtask

  initial begin
    for (int i = 0; i < MS; i++) m_known[i] = 0;
    model_reset();
  end

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rd_known = m_known[rd_addr];
      m_rd = m_mem[rd_addr];
      if (start) begin
        m_target = (int'(len) > MS) ? MS : int'(len);
        m_count = 0;
        m_ovf = 0;
        m_cap = (m_target != 0);
        m_done = (m_target == 0);
      end else if (m_cap && ct_if.ct_valid_i) begin
        m_mem[m_count] = ct_if.ct_i;
        m_known[m_count] = 1;
        m_count++;
        if (m_count == m_target) begin
          m_cap = 0;
          m_done = 1;
        end
      end else if (m_done && ct_if.ct_valid_i) begin
        m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", TW'(ct_if.ct_ready_o), TW'(m_cap));
      check("done", TW'(done), TW'(m_done));
      check("ovf", TW'(overflow), TW'(m_ovf));
      check("count", TW'(count), TW'(m_count));
      check("wr_ptr", TW'(wr_ptr), TW'(m_count % MS));
      if (m_rd_known) check("rd_data", rd_data, m_rd);
    end
  end

  task automatic cyc(bit s, int l, bit v, logic [TW-1:0] d, int a);
    start = s;
    len = (AW+1)'(l);
    ct_if.ct_valid_i = v;
    ct_if.ct_i = d;
    rd_addr = AW'(a);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int a);
    cyc(0, 0, 0, '0, a);
  endtask

  int vpat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int k;

  initial begin
    ct_if.ct_valid_i = 1'b0;
    ct_if.ct_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", TW'(ct_if.ct_ready_o), '0);
    check("rst_done", TW'(done), '0);
    check("rst_count", TW'(count), '0);
    check("rst_rd", rd_data, '0);
    rst_n = 1'b1;
    chk_en = 1;
    idle(0);

    // 4 back-to-back blocks
    cyc(1, 4, 0, '0, 0);
    check("t1_ready", TW'(ct_if.ct_ready_o), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1, TW'(i), 0);
      if (i == 3) check("t1_done_early", TW'(done), 0);
    end
    check("t1_done", TW'(done), 1);
    check("t1_count", TW'(count), 4);
    check("t1_ready_off", TW'(ct_if.ct_ready_o), 0);
    for (int a = 0; a < 4; a++) begin
      idle(a);
      check("t1_rd", rd_data, TW'(a + 1));
    end

    // gapped valid pattern
    cyc(1, 4, 0, '0, 0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (vpat[i] == 1) k++;
      cyc(0, 0, vpat[i] == 1, TW'(32'h10 + k), 0);
      if (i == 2) check("t2_wr_ptr_gap", TW'(wr_ptr), 1);
    end
    check("t2_count", TW'(count), 4);
    check("t2_done", TW'(done), 1);
    idle(3);
    check("t2_rd3", rd_data, TW'(32'h14));

    // len 20 clamps to 16
    cyc(1, 20, 0, '0, 0);
    for (int i = 1; i <= 16; i++) cyc(0, 0, 1, TW'(100 + i), 0);
    check("t3_done", TW'(done), 1);
    check("t3_ready", TW'(ct_if.ct_ready_o), 0);
    check("t3_count", TW'(count), 16);
    cyc(0, 0, 1, TW'(32'hdead), 15);
    check("t3_ovf", TW'(overflow), 1);
    idle(15);
    check("t3_rd15", rd_data, TW'(116));

    // len 0
    cyc(1, 0, 0, '0, 0);
    check("t4_done", TW'(done), 1);
    check("t4_ready", TW'(ct_if.ct_ready_o), 0);
    cyc(0, 0, 1, TW'(32'hbeef), 0);
    check("t4_ovf", TW'(overflow), 1);
    idle(0);

    // start collides with accepted write at count 2
    cyc(1, 8, 0, '0, 0);
    check("t5_ovf_clr", TW'(overflow), 0);
    cyc(0, 0, 1, TW'(32'h51), 0);
    cyc(0, 0, 1, TW'(32'h52), 0);
    check("t5_count2", TW'(count), 2);
    cyc(1, 8, 1, TW'(32'hbad), 2);
    check("t5_count0", TW'(count), 0);
    check("t5_wr_ptr0", TW'(wr_ptr), 0);
    check("t5_ovf", TW'(overflow), 0);
    idle(2);
    check("t5_rd2", rd_data, TW'(103));

    // async reset mid-run at count 3
    cyc(1, 8, 0, '0, 0);
    cyc(0, 0, 1, TW'(32'h71), 0);
    cyc(0, 0, 1, TW'(32'h72), 0);
    cyc(0, 0, 1, TW'(32'h73), 0);
    check("t6_count3", TW'(count), 3);
    ct_if.ct_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", TW'(ct_if.ct_ready_o), 0);
    check("t6_rst_count", TW'(count), 0);
    check("t6_rst_wr_ptr", TW'(wr_ptr), 0);
    check("t6_rst_done", TW'(done), 0);
    check("t6_rst_rd", rd_data, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(0);
    cyc(1, 4, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    check("t6_old_rd0", rd_data, TW'(32'h71));
    check("t6_count_hold", TW'(count), 0);
    idle(0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
